// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - multiplexed seven-segment scanner with frame-synchronised double buffering
module disp_scan_ctrl #(
    parameter int DIGITS    = 8,
    parameter int SEL_W     = 3,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic [DIGITS-1:0]     dp_mask,
    output logic [7:0]            led,
    output logic [SEL_W-1:0]      which,
    output logic                  shine,
    output logic                  busy,
    output logic                  updated
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(DIGITS - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_DIV - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic [FC_W-1:0]      frame_cnt;
    logic                 blink_phase;
    logic                 tick;
    logic                 frame_end;

    logic [4*DIGITS-1:0]  pend_data;
    logic [DIGITS-1:0]    pend_blank;
    logic [DIGITS-1:0]    pend_blink;
    logic [DIGITS-1:0]    pend_dp;

    logic [4*DIGITS-1:0]  act_data;
    logic [DIGITS-1:0]    act_blank;
    logic [DIGITS-1:0]    act_blink;
    logic [DIGITS-1:0]    act_dp;

    logic [3:0]           cur_nib;
    logic                 cur_blank;
    logic                 cur_blink;
    logic                 cur_dp;

    assign tick      = (div_cnt == DIV_LAST);
    assign frame_end = tick && (which == SEL_LAST);

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Prescaler and digit scan; which never leaves 0..DIGITS-1.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt <= '0;
            which   <= '0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
                which   <= (which == SEL_LAST) ? '0 : which + SEL_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_end) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end

    // Active buffer only changes on a frame boundary, so a frame is never drawn from mixed data.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pend_data  <= '0;
            pend_blank <= '1;
            pend_blink <= '0;
            pend_dp    <= '0;
            act_data   <= '0;
            act_blank  <= '1;
            act_blink  <= '0;
            act_dp     <= '0;
            busy       <= 1'b0;
            updated    <= 1'b0;
        end else begin
            updated <= 1'b0;
            if (load && frame_end) begin
                act_data  <= data;
                act_blank <= blank_mask;
                act_blink <= blink_mask;
                act_dp    <= dp_mask;
                busy      <= 1'b0;
                updated   <= 1'b1;
            end else if (load) begin
                pend_data  <= data;
                pend_blank <= blank_mask;
                pend_blink <= blink_mask;
                pend_dp    <= dp_mask;
                busy       <= 1'b1;
            end else if (frame_end && busy) begin
                act_data  <= pend_data;
                act_blank <= pend_blank;
                act_blink <= pend_blink;
                act_dp    <= pend_dp;
                busy      <= 1'b0;
                updated   <= 1'b1;
            end
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_blank = 1'b1;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (which == SEL_W'(k)) begin
                cur_nib   = act_data[4*k +: 4];
                cur_blank = act_blank[k];
                cur_blink = act_blink[k];
                cur_dp    = act_dp[k];
            end
        end
    end

    always_comb begin
        shine = !cur_blank && !(cur_blink && blink_phase);
        led   = shine ? {cur_dp, seg7(cur_nib)} : 8'h00;
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

    logic        Clk;
    logic        Rst_n;
    logic        load;
    logic [15:0] data;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [7:0]  led;
    logic [1:0]  which;
    logic        shine;
    logic        busy;
    logic        updated;

    int compared   = 0;
    int mismatched = 0;

    disp_scan_ctrl #(
        .DIGITS(4), .SEL_W(2), .SCAN_DIV(4), .BLINK_DIV(2)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .load(load), .data(data),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .dp_mask(dp_mask),
        .led(led), .which(which), .shine(shine), .busy(busy), .updated(updated)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  bk;
        logic [3:0]  bl;
        logic [3:0]  dp;
    } buf_t;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  bk;
        logic [3:0]  dp;
        logic [31:0] exp_led;
        logic [3:0]  exp_sh;
    } vec_t;

    // Reference: time since reset release determines scan position and blink phase.
    int   m_n;
    buf_t m_act;
    buf_t m_pend;
    logic m_busy;
    logic m_upd;

    function automatic logic [7:0] seg(input logic [3:0] v);
        case (v)
            4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
            4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
            4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
            4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        m_n    = 0;
        m_act  = '{16'h0, 4'hF, 4'h0, 4'h0};
        m_pend = '{16'h0, 4'hF, 4'h0, 4'h0};
        m_busy = 1'b0;
        m_upd  = 1'b0;
    endtask

    task automatic check_model();
        int         w;
        int         ph;
        logic       sh;
        logic [7:0] s;
        logic [7:0] le;
        w  = (m_n / 4) % 4;
        ph = (m_n / 32) % 2;
        sh = !m_act.bk[w] && !(m_act.bl[w] && (ph == 1));
        s  = seg(m_act.d[w*4 +: 4]);
        le = sh ? {m_act.dp[w], s[6:0]} : 8'h00;
        chk("m_which",   32'(which),   32'(w));
        chk("m_shine",   32'(shine),   32'(sh));
        chk("m_led",     32'(led),     32'(le));
        chk("m_busy",    32'(busy),    32'(m_busy));
        chk("m_updated", 32'(updated), 32'(m_upd));
    endtask

    // Called at a falling edge: drive inputs, advance the model, sample at the next falling edge.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] bk,
                        input logic [3:0] bl, input logic [3:0] dpm);
        logic fe;
        buf_t nb;
        load = ld; data = d; blank_mask = bk; blink_mask = bl; dp_mask = dpm;
        nb = '{d, bk, bl, dpm};
        fe = ((m_n % 16) == 15);
        m_upd = 1'b0;
        if (ld && fe) begin
            m_act = nb; m_busy = 1'b0; m_upd = 1'b1;
        end else if (ld) begin
            m_pend = nb; m_busy = 1'b1;
        end else if (fe && m_busy) begin
            m_act = m_pend; m_busy = 1'b0; m_upd = 1'b1;
        end
        m_n++;
        @(negedge Clk);
        load = 1'b0;
        check_model();
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_to(input int r);
        for (int i = 0; i < 16 && (m_n % 16) != r; i++) idle();
    endtask

    task automatic wait_upd(input string nm);
        int n;
        n = 0;
        while (updated !== 1'b1 && n < 40) begin
            idle();
            n++;
        end
        if (updated !== 1'b1) chk({nm, "_timeout"}, 32'(updated), 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        int upd_cnt;
        int dark;
        logic [1:0] w_exp;
        logic [7:0] tmp;

        vecs[0] = '{16'h3A10, 4'h0, 4'h0, 32'h4F77063F, 4'hF};
        vecs[1] = '{16'h7654, 4'h0, 4'h0, 32'h077D6D66, 4'hF};
        vecs[2] = '{16'hBA98, 4'h0, 4'h0, 32'h7C776F7F, 4'hF};
        vecs[3] = '{16'hFEDC, 4'h0, 4'h0, 32'h71795E39, 4'hF};
        vecs[4] = '{16'h2222, 4'h8, 4'h2, 32'h005BDB5B, 4'h7};

        Rst_n = 1'b0; load = 1'b0; data = '0;
        blank_mask = '0; blink_mask = '0; dp_mask = '0;
        m_reset();
        repeat (2) @(negedge Clk);
        chk("rst_led",   32'(led),     32'h00);
        chk("rst_shine", 32'(shine),   32'd0);
        chk("rst_which", 32'(which),   32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_upd",   32'(updated), 32'd0);
        Rst_n = 1'b1;

        // Idle scan: digit index steps every 4 cycles, display stays dark.
        for (int i = 0; i < 20; i++) begin
            idle();
            w_exp = 2'(((i + 1) / 4) % 4);
            chk("idle_which", 32'(which), 32'(w_exp));
            chk("idle_led",   32'(led),   32'h00);
            chk("idle_shine", 32'(shine), 32'd0);
        end

        // Table: load mid-frame, commit at frame end, verify every digit of the next frame.
        for (int v = 0; v < 5; v++) begin
            idle_to(4);
            step(1'b1, vecs[v].d, vecs[v].bk, 4'h0, vecs[v].dp);
            chk("tbl_busy", 32'(busy), 32'd1);
            wait_upd("tbl_upd");
            chk("tbl_frame_start", 32'(which), 32'd0);
            upd_cnt = 0;
            for (int k = 0; k < 4; k++) begin
                tmp = vecs[v].exp_led[8*k +: 8];
                chk($sformatf("tbl%0d_led%0d", v, k), 32'(led), 32'(tmp));
                chk($sformatf("tbl%0d_sh%0d", v, k), 32'(shine), 32'(vecs[v].exp_sh[k]));
                repeat (4) begin
                    idle();
                    if (updated) upd_cnt++;
                end
            end
            chk("tbl_upd_once", 32'(upd_cnt), 32'd0);
        end

        // Two loads in one frame: last one wins.
        idle_to(2);
        step(1'b1, 16'h1111, 4'h0, 4'h0, 4'h0);
        repeat (3) idle();
        step(1'b1, 16'h2222, 4'h0, 4'h0, 4'h0);
        wait_upd("dbl_upd");
        for (int k = 0; k < 4; k++) begin
            chk("dbl_led", 32'(led), 32'h5B);
            repeat (4) idle();
        end

        // Load on the frame_end cycle bypasses pending.
        idle_to(15);
        chk("byp_busy_before", 32'(busy), 32'd0);
        step(1'b1, 16'h4567, 4'h0, 4'h0, 4'h0);
        chk("byp_busy", 32'(busy),    32'd0);
        chk("byp_upd",  32'(updated), 32'd1);
        chk("byp_led0", 32'(led),     32'h07);
        idle();
        chk("byp_upd_low", 32'(updated), 32'd0);

        // Blink on digit 0, decimal point on digit 1.
        idle_to(15);
        step(1'b1, 16'h0000, 4'h0, 4'h1, 4'h2);
        dark = 0;
        for (int f = 0; f < 4; f++) begin
            chk("blink_d0", 32'(shine), 32'(((m_n / 32) % 2) == 0));
            if (!shine) dark++;
            repeat (4) idle();
            chk("dp_d1", 32'(led), 32'hBF);
            repeat (12) idle();
        end
        chk("blink_dark_frames", 32'(dark), 32'd2);

        // Random traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 6) == 0, 16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Asynchronous reset while a load is pending.
        idle_to(5);
        step(1'b1, 16'h9999, 4'h0, 4'h0, 4'h0);
        repeat (3) idle();
        chk("rst_mid_busy_before", 32'(busy), 32'd1);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_which", 32'(which),   32'd0);
        chk("arst_busy",  32'(busy),    32'd0);
        chk("arst_led",   32'(led),     32'h00);
        chk("arst_shine", 32'(shine),   32'd0);
        chk("arst_upd",   32'(updated), 32'd0);
        m_reset();
        @(negedge Clk);
        Rst_n = 1'b1;
        upd_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            idle();
            if (updated) upd_cnt++;
        end
        chk("arst_no_commit", 32'(upd_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
